// File: rtl/txwbcnt_pkg.sv
// Shared defaults and helpers for the single-clock TX write-byte-count FIFO.
// Holds the byte-count field extraction and the qbytes width legality rule.
package txwbcnt_pkg;

    localparam int TXW_WIDTH = 32;
    localparam int TXW_DEPTH = 8;
    localparam int TXW_PTR   = 3;
    localparam int TXW_CNTW  = 16;
    localparam int TXW_SUMW  = 20;

    // qbytes must hold DEPTH full-scale counts without wrapping.
    localparam bit TXW_DEFAULT_SUMW_OK = (TXW_SUMW >= TXW_CNTW + TXW_PTR + 1);

    typedef struct packed {
        logic full;
        logic empty;
        logic afull;
    } lvl_flags_t;

    function automatic bit sumw_legal(input int sumw, input int cntw, input int ptr);
        return sumw >= cntw + ptr + 1;
    endfunction

    function automatic logic [63:0] cnt_field(input logic [63:0] word, input int cntw);
        logic [63:0] mask;
        mask = (64'd1 << cntw) - 64'd1;
        return word & mask;
    endfunction

endpackage

// File: rtl/txwbcnt_fifo_mem.sv
// DEPTH x WIDTH descriptor storage: one write port, one read address.
// The head word is always visible; rdata_o is registered unless FWFT is set.
module txwbcnt_fifo_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int PTR   = 3,
    parameter int FWFT  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we_i,
    input  logic [PTR-1:0]   waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [PTR-1:0]   raddr_i,
    output logic [WIDTH-1:0] head_o,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // NOTE: the storage array is deliberately not reset; the pointers decide
    // which entries are valid, and resetting it would block RAM inference.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign head_o = mem_q[raddr_i];

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= head_o;
        end
    end

    assign rdata_o = (FWFT != 0) ? head_o : rdata_q;

endmodule

// File: rtl/txwbcnt_sync_fifo.sv
// Single-clock descriptor FIFO for the AXIS bridge TX path with level flags,
// running byte total of queued frames and sticky overflow/underflow flags.
module txwbcnt_sync_fifo
    import txwbcnt_pkg::*;
#(
    parameter int WIDTH    = TXW_WIDTH,
    parameter int DEPTH    = TXW_DEPTH,
    parameter int PTR      = TXW_PTR,
    parameter int FWFT     = 0,
    parameter int AFULL_TH = 6,
    parameter int CNTW     = TXW_CNTW,
    parameter int SUMW     = TXW_SUMW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wren,
    input  logic [WIDTH-1:0] datain,
    input  logic             rden,
    output logic [WIDTH-1:0] dataout,
    output logic             dout_vld,
    output logic             full,
    output logic             empty,
    output logic             afull,
    output logic [PTR:0]     usedw,
    output logic [SUMW-1:0]  qbytes,
    output logic             ovf,
    output logic             udf,
    input  logic             err_clr,
    output logic             dbg
);

    if (DEPTH != 2 ** PTR) begin : g_bad_depth
        $error("txwbcnt_sync_fifo: DEPTH must equal 2**PTR");
    end
    if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
        $error("txwbcnt_sync_fifo: AFULL_TH out of range 1..DEPTH");
    end
    if (CNTW > WIDTH || CNTW > 64) begin : g_bad_cntw
        $error("txwbcnt_sync_fifo: CNTW too wide");
    end
    if (!TXW_DEFAULT_SUMW_OK || !sumw_legal(SUMW, CNTW, PTR)) begin : g_bad_sumw
        $error("txwbcnt_sync_fifo: SUMW too narrow for DEPTH byte counts");
    end

    logic [PTR:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR:0]      usedw_q, usedw_d;
    lvl_flags_t        lvl_q, lvl_d;
    logic [SUMW-1:0]   qbytes_q, qbytes_d, wr_cnt, rd_cnt;
    logic              ovf_q, ovf_d, udf_q, udf_d, dbg_q, dbg_d, vld_q;
    logic              wa, ra, wr_rej, rd_rej;
    logic [WIDTH-1:0]  head, rdata;

    // Acceptance uses the registered flags, i.e. the state at the start of the cycle.
    assign wa     = wren & ~lvl_q.full;
    assign ra     = rden & ~lvl_q.empty;
    assign wr_rej = wren & lvl_q.full;
    assign rd_rej = rden & lvl_q.empty;

    assign wr_cnt = SUMW'(cnt_field(64'(datain), CNTW));
    assign rd_cnt = SUMW'(cnt_field(64'(head), CNTW));

    // NOTE: every always_comb output is assigned on every path, so no latches form.
    always_comb begin
        wr_ptr_d    = wr_ptr_q + (PTR+1)'(wa);
        rd_ptr_d    = rd_ptr_q + (PTR+1)'(ra);
        usedw_d     = wr_ptr_d - rd_ptr_d;
        lvl_d.full  = (wr_ptr_d[PTR] != rd_ptr_d[PTR]) &&
                      (wr_ptr_d[PTR-1:0] == rd_ptr_d[PTR-1:0]);
        lvl_d.empty = (wr_ptr_d == rd_ptr_d);
        lvl_d.afull = (usedw_d >= (PTR+1)'(AFULL_TH));
        qbytes_d    = qbytes_q + (wa ? wr_cnt : '0) - (ra ? rd_cnt : '0);
        ovf_d       = wr_rej | (ovf_q & ~err_clr);
        udf_d       = rd_rej | (udf_q & ~err_clr);
        dbg_d       = wr_rej | rd_rej;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            usedw_q  <= '0;
            lvl_q    <= '{full: 1'b0, empty: 1'b1, afull: 1'b0};
            qbytes_q <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            dbg_q    <= 1'b0;
            vld_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            usedw_q  <= usedw_d;
            lvl_q    <= lvl_d;
            qbytes_q <= qbytes_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            dbg_q    <= dbg_d;
            vld_q    <= ra;
        end
    end

    txwbcnt_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PTR   (PTR),
        .FWFT  (FWFT)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .we_i    (wa & ~reset),
        .waddr_i (wr_ptr_q[PTR-1:0]),
        .wdata_i (datain),
        .re_i    (ra & ~reset),
        .raddr_i (rd_ptr_q[PTR-1:0]),
        .head_o  (head),
        .rdata_o (rdata)
    );

    // In FWFT mode stale storage is masked so an empty FIFO shows zero.
    assign dataout  = (FWFT != 0) ? (lvl_q.empty ? '0 : rdata) : rdata;
    assign dout_vld = (FWFT != 0) ? ~lvl_q.empty : vld_q;
    assign full     = lvl_q.full;
    assign empty    = lvl_q.empty;
    assign afull    = lvl_q.afull;
    assign usedw    = usedw_q;
    assign qbytes   = qbytes_q;
    assign ovf      = ovf_q;
    assign udf      = udf_q;
    assign dbg      = dbg_q;

endmodule

// File: tb/tb_txwbcnt_sync_fifo.sv
// Bench for txwbcnt_sync_fifo: a registered-read and an FWFT instance share
// stimulus and are compared against a queue model plus a directed vector table.
module tb_txwbcnt_sync_fifo;

    localparam int W  = 32;
    localparam int D  = 8;
    localparam int P  = 3;
    localparam int CW = 16;
    localparam int SW = 20;
    localparam int AT = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, wren, rden, err_clr;
    logic [W-1:0]  datain;

    logic [W-1:0]  dout0, dout1;
    logic          vld0, vld1, full0, full1, empty0, empty1, afull0, afull1;
    logic [P:0]    usedw0, usedw1;
    logic [SW-1:0] qb0, qb1;
    logic          ovf0, ovf1, udf0, udf1, dbg0, dbg1;

    txwbcnt_sync_fifo #(.WIDTH(W), .DEPTH(D), .PTR(P), .FWFT(0), .AFULL_TH(AT),
                        .CNTW(CW), .SUMW(SW)) dut (
        .clk(clk), .reset(reset), .wren(wren), .datain(datain), .rden(rden),
        .dataout(dout0), .dout_vld(vld0), .full(full0), .empty(empty0),
        .afull(afull0), .usedw(usedw0), .qbytes(qb0), .ovf(ovf0), .udf(udf0),
        .err_clr(err_clr), .dbg(dbg0));

    txwbcnt_sync_fifo #(.WIDTH(W), .DEPTH(D), .PTR(P), .FWFT(1), .AFULL_TH(AT),
                        .CNTW(CW), .SUMW(SW)) dut_fwft (
        .clk(clk), .reset(reset), .wren(wren), .datain(datain), .rden(rden),
        .dataout(dout1), .dout_vld(vld1), .full(full1), .empty(empty1),
        .afull(afull1), .usedw(usedw1), .qbytes(qb1), .ovf(ovf1), .udf(udf1),
        .err_clr(err_clr), .dbg(dbg1));

    int    n_tests = 0;
    int    n_fail  = 0;
    string phase   = "init";

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s/%s: got 0x%0h expected 0x%0h at %0t", phase, name, act, exp, $time);
        end
    endtask

    // Reference model: the FIFO contents as a queue, flags from its size.
    logic [W-1:0] mq[$];
    bit           m_ovf, m_udf, m_dbg, m_vld0;
    logic [W-1:0] m_dout0;

    function automatic int m_qbytes();
        int s = 0;
        foreach (mq[i]) s += int'(mq[i][CW-1:0]);
        return s;
    endfunction

    task automatic compare_model();
        int n;
        n = mq.size();
        check("usedw",   64'(usedw0), 64'(n));
        check("full",    64'(full0),  64'(n == D));
        check("empty",   64'(empty0), 64'(n == 0));
        check("afull",   64'(afull0), 64'(n >= AT));
        check("qbytes",  64'(qb0),    64'(m_qbytes()));
        check("ovf",     64'(ovf0),   64'(m_ovf));
        check("udf",     64'(udf0),   64'(m_udf));
        check("dbg",     64'(dbg0),   64'(m_dbg));
        check("vld",     64'(vld0),   64'(m_vld0));
        check("dout",    64'(dout0),  64'(m_dout0));
        check("f_usedw", 64'(usedw1), 64'(n));
        check("f_qbytes",64'(qb1),    64'(m_qbytes()));
        check("f_vld",   64'(vld1),   64'(n > 0));
        check("f_dout",  64'(dout1),  (n > 0) ? 64'(mq[0]) : 64'd0);
    endtask

    task automatic step(input bit rst, input bit wr, input logic [W-1:0] din,
                        input bit rd, input bit clr);
        bit pre_full, pre_empty;
        reset   = rst;
        wren    = wr;
        datain  = din;
        rden    = rd;
        err_clr = clr;
        pre_full  = (mq.size() == D);
        pre_empty = (mq.size() == 0);
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_ovf = 0; m_udf = 0; m_dbg = 0; m_vld0 = 0; m_dout0 = '0;
        end else begin
            m_dbg  = (wr && pre_full) || (rd && pre_empty);
            m_ovf  = (wr && pre_full) || (m_ovf && !clr);
            m_udf  = (rd && pre_empty) || (m_udf && !clr);
            m_vld0 = rd && !pre_empty;
            if (m_vld0) m_dout0 = mq.pop_front();
            if (wr && !pre_full) mq.push_back(din);
        end
        #1;
        compare_model();
    endtask

    typedef struct {
        bit          rst, wr, rd, clr;
        logic [W-1:0] din;
        int          uw, qb;
        bit          fu, em, af, ov, ud, db, vl;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit rst, bit wr, logic [W-1:0] din, bit rd, bit clr,
                                int uw, bit fu, bit em, bit af, int qb,
                                bit ov, bit ud, bit db, bit vl);
        vec_t v;
        v.rst = rst; v.wr = wr; v.din = din; v.rd = rd; v.clr = clr;
        v.uw = uw; v.fu = fu; v.em = em; v.af = af; v.qb = qb;
        v.ov = ov; v.ud = ud; v.db = db; v.vl = vl;
        return v;
    endfunction

    initial begin
        int qb;
        reset = 1'b1; wren = 1'b0; rden = 1'b0; err_clr = 1'b0; datain = '0;

        // Directed table: fill to full, overflow, drain, underflow, clear priority.
        vecs.push_back(mk(1,0,0,0,0, 0,0,1,0,0, 0,0,0,0));
        for (int k = 1; k <= 8; k++) begin
            qb = k * 64 + k * (k - 1) / 2;
            vecs.push_back(mk(0,1,32'hC0DE_0000 | W'(63 + k),0,0, k,(k == 8),0,(k >= AT),qb, 0,0,0,0));
        end
        vecs.push_back(mk(0,1,32'hC0DE_0048,1,0, 7,0,0,1,476, 1,0,1,1));
        vecs.push_back(mk(0,0,0,0,1, 7,0,0,1,476, 0,0,0,0));
        qb = 476;
        for (int k = 1; k <= 7; k++) begin
            qb -= 64 + k;
            vecs.push_back(mk(0,0,0,1,0, 7-k,0,(k == 7),((7-k) >= AT),qb, 0,0,0,1));
        end
        vecs.push_back(mk(0,0,0,1,0, 0,0,1,0,0, 0,1,1,0));
        vecs.push_back(mk(0,0,0,0,0, 0,0,1,0,0, 0,1,0,0));
        vecs.push_back(mk(0,0,0,1,1, 0,0,1,0,0, 0,1,1,0));
        vecs.push_back(mk(0,0,0,0,1, 0,0,1,0,0, 0,0,0,0));
        vecs.push_back(mk(0,1,32'h100,0,0, 1,0,0,0,256, 0,0,0,0));
        vecs.push_back(mk(0,0,0,1,0, 0,0,1,0,0, 0,0,0,1));
        vecs.push_back(mk(0,0,0,0,0, 0,0,1,0,0, 0,0,0,0));

        phase = "table";
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].wr, vecs[i].din, vecs[i].rd, vecs[i].clr);
            check("t_usedw", 64'(usedw0), 64'(vecs[i].uw));
            check("t_full",  64'(full0),  64'(vecs[i].fu));
            check("t_empty", 64'(empty0), 64'(vecs[i].em));
            check("t_afull", 64'(afull0), 64'(vecs[i].af));
            check("t_qbytes",64'(qb0),    64'(vecs[i].qb));
            check("t_ovf",   64'(ovf0),   64'(vecs[i].ov));
            check("t_udf",   64'(udf0),   64'(vecs[i].ud));
            check("t_dbg",   64'(dbg0),   64'(vecs[i].db));
            check("t_vld",   64'(vld0),   64'(vecs[i].vl));
            if (i == 9) check("t_pop64", 64'(dout0), 64'h0000_0000_C0DE_0040);
        end

        // Read latency: FWFT shows the word before rden, registered mode one cycle after.
        phase = "latency";
        step(1, 0, 0, 0, 0);
        step(0, 1, 32'h100, 0, 0);
        check("fwft_dout", 64'(dout1), 64'h100);
        check("fwft_vld",  64'(vld1),  64'd1);
        check("reg_vld0",  64'(vld0),  64'd0);
        step(0, 0, 0, 1, 0);
        check("reg_dout",  64'(dout0), 64'h100);
        check("reg_vld1",  64'(vld0),  64'd1);
        step(0, 0, 0, 0, 0);
        check("reg_vld2",  64'(vld0),  64'd0);

        // Streaming across the pointer wrap with a constant fill level of 3.
        phase = "stream";
        for (int i = 0; i < 3; i++) step(0, 1, W'($urandom), 0, 0);
        for (int i = 0; i < 20; i++) begin
            step(0, 1, W'($urandom), 1, 0);
            check("s_usedw", 64'(usedw0), 64'd3);
        end

        // Reset with 5 entries stored and a write in the reset cycle.
        phase = "midreset";
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, W'($urandom), 0, 0);
        step(1, 1, 32'h0000_1234, 0, 0);
        check("r_usedw", 64'(usedw0), 64'd0);
        check("r_empty", 64'(empty0), 64'd1);
        check("r_qbytes",64'(qb0),    64'd0);
        step(0, 0, 0, 0, 0);
        check("r_fvld",  64'(vld1),   64'd0);
        check("r_usedw2",64'(usedw1), 64'd0);

        // Randomised traffic with shifting write/read bias and rare resets.
        phase = "random";
        for (int i = 0; i < 600; i++) begin
            int wb, rb;
            wb = ((i / 50) % 3 == 0) ? 80 : (((i / 50) % 3 == 1) ? 30 : 55);
            rb = 100 - wb;
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < wb),
                 W'($urandom), ($urandom_range(0, 99) < rb), ($urandom_range(0, 15) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
